oric_ram_arbiter: RTL
=====================

# oric_ram_arbiter

Single-port main-RAM arbiter sitting between the oricatmos core RAM port, the cassette loader's tape write port and the 64 KB main RAM. After reset it fills the whole RAM with a constant while holding the core in reset. It then serves core accesses with a fixed registered latency. Tape writes are buffered in a small FIFO and drained into idle RAM cycles, so the RAM needs only one port.

## Interface
Parameters:
- AW, 16, RAM address width; clear length 2^AW.
- FILL, 8'hFF, byte written to every location during clear.
- FIFO_DEPTH, 4, tape write buffer entries (power of two, ≥2).

Ports:
- clk_48  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_ad  in  AW  core address.
- cpu_d  in  8  core write data.
- cpu_cs  in  1  core access request (level, sampled every cycle).
- cpu_we  in  1  core write enable (qualified by cpu_cs).
- cpu_q  out  8  read data; combinational pass-through of mem_q.
- core_reset  out  1  reset to the core = reset OR clearing.
- tape_addr  in  AW  loader write address.
- tape_dout  in  8  loader write data.
- tape_wr  in  1  one-cycle write strobe.
- tape_overflow  out  1  sticky; a tape write was dropped.
- clear_busy  out  1  high while in CLEAR.
- mem_a  out  AW  RAM address (registered).
- mem_d  out  8  RAM write data (registered).
- mem_ce  out  1  RAM enable (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_q  in  8  RAM synchronous read data, valid one cycle after mem_a.

## Operation
- FSM states: CLEAR and RUN.
  - reset high → CLEAR with clear counter = 0.
  - CLEAR → RUN once the write to address 2^AW−1 has been issued.
- CLEAR behaviour:
  - One write per cycle: mem_a = counter, mem_d = FILL, mem_ce = mem_we = 1.
  - While reset is high the counter holds at 0 and the write to address 0 repeats.
  - cpu_cs is ignored.
  - Tape writes are accepted into the FIFO but not drained.
- RUN arbitration, evaluated per cycle:
  1. If cpu_cs = 1, the core wins: mem ← {cpu_ad, cpu_d, ce=1, we=cpu_we}.
  2. Otherwise, if the FIFO is non-empty: pop and write {addr, data, ce=1, we=1}.
  3. Otherwise idle: mem_ce = mem_we = 0, and mem_a/mem_d hold their values.
- Tape FIFO:
  - Push on tape_wr.
  - If tape_wr arrives while full and there is no pop in the same cycle: drop the write and set tape_overflow.
  - If full with a push and pop in the same cycle: accept the push.
  - Pointers wrap modulo FIFO_DEPTH; occupancy count is log2(FIFO_DEPTH)+1 bits.
- Ordering: the RAM receives tape writes in FIFO order. Core writes are not checked against buffered tape entries, so a later tape drain to the same address overwrites the core's write.
- tape_overflow clears only on reset.
- Reset mid-operation: FIFO is emptied, tape_overflow = 0, state returns to CLEAR and the full clear restarts.

## Timing
- Reset values (cycle after reset sampled high):
  - clear_busy = 1, core_reset = 1.
  - mem_a = 0, mem_d = FILL, mem_ce = 1, mem_we = 1.
  - tape_overflow = 0, FIFO empty.
- Clear duration: the first cycle with reset low issues address 0. Addresses 0 … 2^AW−1 are issued on consecutive cycles, 2^AW cycles in total. clear_busy and core_reset drop in the cycle after the last clear write is issued.
- Core latency:
  - cpu_cs sampled at edge N → mem_* valid after edge N (one-cycle registered issue).
  - Read data appears on cpu_q after edge N+1.
- Tape latency: a tape_wr sampled at edge N with cpu_cs low on the following cycles and the FIFO otherwise empty → RAM write issued after edge N+1.
- Steady core request (cpu_cs high every cycle) starves the FIFO indefinitely; no fairness guarantee.

## Structure
- Package oric_ram_pkg holds:
  - the state enum {ST_CLEAR, ST_RUN};
  - the source enum {SRC_IDLE, SRC_CPU, SRC_TAPE, SRC_CLEAR};
  - a packed struct tape_wr_t {addr[AW], data[8]}.
- One sub-module, oric_tape_fifo:
  - parameterised on depth and data width;
  - ports: push, pop, din, dout, full, empty;
  - reports a dropped push via an overflow pulse.
- The top module holds the FSM, the clear counter, the arbitration mux and the output registers.

## Test plan
- Reset held 10 cycles, then released → exactly 65536 consecutive writes of 0xFF to addresses 0000–FFFF. core_reset falls one cycle after the FFFF write; a subsequent core read of 1234 returns FF.
- RUN: core write 5A to C000, then read C000 → mem_we pulse one cycle after the request; cpu_q = 5A two cycles after the read request.
- tape_wr to 0500 = 11, 0501 = 22 with cpu_cs low → RAM writes issued in order on the cycles immediately following each strobe; tape_overflow stays 0.
- cpu_cs held high for 20 cycles while 6 tape strobes arrive (depth 4) → first 4 buffered, last 2 dropped, tape_overflow = 1. After cpu_cs drops, exactly 4 writes drain in FIFO order.
- FIFO full and tape_wr coincident with a pop (cpu_cs low) → write accepted, no overflow.
- Reset asserted mid-drain with 3 entries pending → FIFO emptied, no tape writes issued, full clear restarts at address 0.

Source files
------------

// File: rtl/oric_ram_pkg.sv
// Shared types for the Oric main-RAM arbiter: FSM states, bus-source tags and
// the tape write record.
package oric_ram_pkg;

  localparam int RAM_AW = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_IDLE  = 2'd0,
    SRC_CPU   = 2'd1,
    SRC_TAPE  = 2'd2,
    SRC_CLEAR = 2'd3
  } src_e;

  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic [7:0]        data;
  } tape_wr_t;

endpackage

// File: rtl/oric_ram_arbiter_if.sv
// RAM-side bus of the arbiter: master drives address/data/enables, the RAM
// returns synchronous read data.
interface oric_ram_arbiter_if #(
  parameter int AW = 16
);
  // Protocol: mem_ce=1 on a cycle starts an access at mem_a; mem_we=1 makes it
  // a write of mem_d. For a read, mem_q is valid in the cycle after mem_a was
  // presented. There is no back-pressure: the RAM accepts every cycle.
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_d;
  logic          mem_ce;
  logic          mem_we;
  logic [7:0]    mem_q;

  modport master (
    output mem_a,
    output mem_d,
    output mem_ce,
    output mem_we,
    input  mem_q
  );

  modport slave (
    input  mem_a,
    input  mem_d,
    input  mem_ce,
    input  mem_we,
    output mem_q
  );
endinterface

// File: rtl/oric_tape_fifo.sv
// Small synchronous FIFO buffering cassette-loader writes until the RAM has an
// idle cycle. A push while full with no simultaneous pop is dropped.
module oric_tape_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  buf_q [DEPTH];
  logic [W-1:0]  buf_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign dout  = buf_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && full && !pop_ok;

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      buf_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/oric_ram_arbiter.sv
// Single-port main-RAM arbiter: clears RAM after reset, then serves the core
// with priority and drains buffered tape writes into idle cycles.
module oric_ram_arbiter
  import oric_ram_pkg::*;
#(
  parameter int         AW         = 16,
  parameter logic [7:0] FILL       = 8'hFF,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                 clk_48,
  input  logic                 reset,
  input  logic [AW-1:0]        cpu_ad,
  input  logic [7:0]           cpu_d,
  input  logic                 cpu_cs,
  input  logic                 cpu_we,
  output logic [7:0]           cpu_q,
  output logic                 core_reset,
  input  logic [AW-1:0]        tape_addr,
  input  logic [7:0]           tape_dout,
  input  logic                 tape_wr,
  output logic                 tape_overflow,
  output logic                 clear_busy,
  oric_ram_arbiter_if.master   mem,
  output state_e               state_dbg
);
  localparam int TW = AW + 8;

  state_e        state_q, state_d;
  src_e          src;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [7:0]    mem_d_q, mem_d_d;
  logic          mem_ce_q, mem_ce_d;
  logic          mem_we_q, mem_we_d;
  logic          ovf_q, ovf_d;
  logic          clear_busy_q, clear_busy_d;

  logic          fifo_pop;
  logic [TW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;

  oric_tape_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TW)
  ) u_tape_fifo (
    .clk      (clk_48),
    .rst      (reset),
    .push     (tape_wr),
    .pop      (fifo_pop),
    .din      ({tape_addr, tape_dout}),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_a_d      = mem_a_q;
    mem_d_d      = mem_d_q;
    mem_ce_d     = 1'b0;
    mem_we_d     = 1'b0;
    src          = SRC_IDLE;
    fifo_pop     = 1'b0;
    ovf_d        = ovf_q | fifo_ovf;
    // Registered so the core stays in reset through the cycle showing the last clear write.
    clear_busy_d = (state_q == ST_CLEAR);

    case (state_q)
      ST_CLEAR: begin
        src   = SRC_CLEAR;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cpu_cs) begin
          src = SRC_CPU;
        end else if (!fifo_empty) begin
          src      = SRC_TAPE;
          fifo_pop = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    case (src)
      SRC_CLEAR: begin
        mem_a_d  = cnt_q;
        mem_d_d  = FILL;
        mem_ce_d = 1'b1;
        mem_we_d = 1'b1;
      end
      SRC_CPU: begin
        mem_a_d  = cpu_ad;
        mem_d_d  = cpu_d;
        mem_ce_d = 1'b1;
        mem_we_d = cpu_we;
      end
      SRC_TAPE: begin
        mem_a_d  = fifo_dout[TW-1:8];
        mem_d_d  = fifo_dout[7:0];
        mem_ce_d = 1'b1;
        mem_we_d = 1'b1;
      end
      default: ;
    endcase

    // Reset keeps issuing the address-0 fill write so the clear starts cleanly.
    if (reset) begin
      state_d      = ST_CLEAR;
      cnt_d        = '0;
      mem_a_d      = '0;
      mem_d_d      = FILL;
      mem_ce_d     = 1'b1;
      mem_we_d     = 1'b1;
      ovf_d        = 1'b0;
      clear_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_48) begin
    state_q      <= state_d;
    cnt_q        <= cnt_d;
    mem_a_q      <= mem_a_d;
    mem_d_q      <= mem_d_d;
    mem_ce_q     <= mem_ce_d;
    mem_we_q     <= mem_we_d;
    ovf_q        <= ovf_d;
    clear_busy_q <= clear_busy_d;
  end

  assign mem.mem_a     = mem_a_q;
  assign mem.mem_d     = mem_d_q;
  assign mem.mem_ce    = mem_ce_q;
  assign mem.mem_we    = mem_we_q;
  assign cpu_q         = mem.mem_q;
  assign clear_busy    = clear_busy_q;
  assign core_reset    = reset | clear_busy_q;
  assign tape_overflow = ovf_q;
  assign state_dbg     = state_q;

endmodule
